midlab_inverse: RTL
===================

Name: midlab_inverse

Overview:
- Sequential inverse mapper for the midlab four-function logic block, which maps a 4-bit input abcd to a 4-bit output f1..f4.
- Accepts a target output code {f1,f2,f3,f4} over a valid/ready request channel.
- Scans all 16 candidate input codes, one per clock, through an embedded midlab instance.
- Returns one preimage abcd, a found flag and the total preimage count over a valid/ready response channel. Used by bench and self-test logic that must drive midlab to a wanted output.

Parameters:
- PICK_LOWEST, 1: 1 = report the lowest matching candidate; 0 = report the highest matching candidate.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- req_valid  input  1  request present.
- req_ready  output  1  block can accept a request.
- req_target  input  4  target code {f1,f2,f3,f4}; bit 3 = f1.
- rsp_valid  output  1  response present.
- rsp_ready  input  1  consumer accepts the response.
- rsp_abcd  output  4  chosen preimage {a,b,c,d}; bit 3 = a; 0 when not found.
- rsp_found  output  1  at least one preimage exists.
- rsp_count  output  5  number of preimages, 0..16.
- busy  output  1  high in SCAN or DONE.

Behaviour:
- Interface: one clock, reset is synchronous and active-high.
- Reset values: state = IDLE, req_ready = 1, rsp_valid = 0, rsp_abcd = 0, rsp_found = 0, rsp_count = 0, busy = 0, candidate = 0.
- Reset mid-SCAN or mid-DONE discards the operation. No response is issued.

States:
- IDLE: req_ready = 1.
  - On req_valid && req_ready: latch req_target; clear candidate, count and found; go to SCAN.
- SCAN: req_ready = 0.
  - Each cycle, feed candidate to midlab.
  - If the midlab output == latched target: count += 1. Also record candidate into rsp_abcd when found == 0, or when PICK_LOWEST == 0. Then set found = 1.
  - candidate increments; when candidate == 15 it is evaluated, then the state goes to DONE. Candidate wrap to 0 is never used as a loop condition.
- DONE: rsp_valid = 1.
  - rsp_abcd, rsp_found and rsp_count are held stable until rsp_ready.
  - On rsp_valid && rsp_ready: go to IDLE. rsp_valid drops the next cycle.

Timing and handshake rules:
- Latency: request accepted at edge k; rsp_valid is high from edge k+17 onward. SCAN lasts exactly 16 cycles, independent of the target.
- req_valid while not in IDLE is ignored; the requester must hold it.
- No request is accepted in the same cycle as the response handshake.
- rsp_ready outside DONE is ignored.
- rsp_count is 5 bits because a count of 16 is legal in principle. For midlab the maximum is 4.
- Outputs are registered; no combinational path from req_* to rsp_*.

Midlab reference map (abcd -> f1f2f3f4, decimal):
- 0→5, 1→6, 2→5, 3→8
- 4→5, 5→6, 6→5, 7→8
- 8→13, 9→14, 10→9, 11→14
- 12→9, 13→10, 14→9, 15→14

Decomposition:
- Shared package: the state encoding (IDLE = 0, SCAN = 1, DONE = 2, 2-bit), CODE_W = 4, COUNT_W = 5, and NUM_CAND = 16.
- Sub-module: instantiate the existing midlab module unchanged as the candidate evaluator (combinational). Do not re-derive its equations.
- The top level holds the FSM, candidate counter and result registers.

Test Plan:
- Reset, then target 5 (PICK_LOWEST = 1) -> after 17 cycles rsp_found = 1, rsp_abcd = 0, rsp_count = 4; with PICK_LOWEST = 0, rsp_abcd = 6.
- Target 14 -> rsp_found = 1, rsp_abcd = 9 (lowest) / 15 (highest), rsp_count = 3. Target 10 -> rsp_abcd = 13, rsp_count = 1.
- Target 0, 7 and 15 each -> rsp_found = 0, rsp_abcd = 0, rsp_count = 0, rsp_valid still asserted at k+17.
- Back-pressure: target 9, hold rsp_ready = 0 for 10 cycles -> outputs stable (rsp_abcd = 10, rsp_count = 3). A req_valid pulsed meanwhile is not accepted (req_ready = 0). The next request is accepted only in the cycle after the handshake.
- Assert rst at SCAN cycle 8 of a target-8 request -> the next cycle is IDLE with req_ready = 1 and rsp_valid = 0, and no response ever appears. A new target-13 request then returns rsp_abcd = 8, rsp_count = 1.
- Back-to-back requests for targets 6 then 5 with rsp_ready tied high -> responses {1,1,2} then {0,1,4} in order. Each response is 17 cycles after its accept.

Source files
------------

// File: rtl/midlab_inverse_pkg.sv
// Shared types and constants for the midlab inverse mapper.
// No logic; constants only.
// Not applicable.
package midlab_inverse_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int CODE_W   = 4;
    localparam int COUNT_W  = 5;
    localparam int NUM_CAND = 16;

    // Final candidate of a scan; the scan ends on this value, not on wrap.
    localparam logic [CODE_W-1:0] LAST_CAND = CODE_W'(NUM_CAND - 1);

endpackage

// File: rtl/midlab_inverse_if.sv
// Request/response channel bundle for the midlab inverse mapper.
// No logic; wires only.
// valid/ready on both the request and the response side.
interface midlab_inverse_if;
    import midlab_inverse_pkg::*;

    logic               req_valid;
    logic               req_ready;
    logic [CODE_W-1:0]  req_target;
    logic               rsp_valid;
    logic               rsp_ready;
    logic [CODE_W-1:0]  rsp_abcd;
    logic               rsp_found;
    logic [COUNT_W-1:0] rsp_count;
    logic               busy;

    // Requester / response consumer side.
    modport master (
        output req_valid, req_target, rsp_ready,
        input  req_ready, rsp_valid, rsp_abcd, rsp_found, rsp_count, busy
    );

    // Inverse mapper side.
    modport slave (
        input  req_valid, req_target, rsp_ready,
        output req_ready, rsp_valid, rsp_abcd, rsp_found, rsp_count, busy
    );
endinterface

// File: rtl/midlab_inverse_midlab.sv
// midlab four-function logic block: abcd -> {f1,f2,f3,f4}.
// Purely combinational, zero cycles.
// No handshake.
module midlab_inverse_midlab
    import midlab_inverse_pkg::*;
(
    input  logic [CODE_W-1:0] i_abcd,
    output logic [CODE_W-1:0] o_f
);

    // Reference map of the block, one entry per input code.
    always_comb begin
        o_f = 4'd0;
        case (i_abcd)
            4'd0:  o_f = 4'd5;
            4'd1:  o_f = 4'd6;
            4'd2:  o_f = 4'd5;
            4'd3:  o_f = 4'd8;
            4'd4:  o_f = 4'd5;
            4'd5:  o_f = 4'd6;
            4'd6:  o_f = 4'd5;
            4'd7:  o_f = 4'd8;
            4'd8:  o_f = 4'd13;
            4'd9:  o_f = 4'd14;
            4'd10: o_f = 4'd9;
            4'd11: o_f = 4'd14;
            4'd12: o_f = 4'd9;
            4'd13: o_f = 4'd10;
            4'd14: o_f = 4'd9;
            4'd15: o_f = 4'd14;
            default: o_f = 4'd0;
        endcase
    end

endmodule

// File: rtl/midlab_inverse.sv
// Inverse mapper: finds abcd codes that drive midlab to a requested output.
// Latency: accept at edge k, rsp_valid from edge k+17 (16-cycle fixed scan).
// req_ready only in IDLE; response held in DONE until rsp_ready.
module midlab_inverse
    import midlab_inverse_pkg::*;
#(
    parameter bit PICK_LOWEST = 1'b1
)(
    input  logic             clk,
    input  logic             rst,
    midlab_inverse_if.slave  i_bus
);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [CODE_W-1:0]  r_target,    w_target_nxt;
    logic [CODE_W-1:0]  r_cand,      w_cand_nxt;
    logic [COUNT_W-1:0] r_count,     w_count_nxt;
    logic [CODE_W-1:0]  r_abcd,      w_abcd_nxt;
    logic               r_found,     w_found_nxt;
    logic               r_rsp_valid, w_rsp_valid_nxt;
    logic               r_req_ready, w_req_ready_nxt;
    logic               r_busy,      w_busy_nxt;

    logic [CODE_W-1:0]  w_f;
    logic               w_match;

    midlab_inverse_midlab u_midlab (
        .i_abcd (r_cand),
        .o_f    (w_f)
    );

    assign w_match = (w_f == r_target);

    // Next-state and next-output logic for the scan FSM.
    always_comb begin
        w_state_nxt     = r_state;
        w_target_nxt    = r_target;
        w_cand_nxt      = r_cand;
        w_count_nxt     = r_count;
        w_abcd_nxt      = r_abcd;
        w_found_nxt     = r_found;
        w_rsp_valid_nxt = r_rsp_valid;

        case (r_state)
            ST_IDLE: begin
                w_rsp_valid_nxt = 1'b0;
                if (i_bus.req_valid && r_req_ready) begin
                    w_target_nxt = i_bus.req_target;
                    w_cand_nxt   = '0;
                    w_count_nxt  = '0;
                    w_found_nxt  = 1'b0;
                    w_abcd_nxt   = '0;
                    w_state_nxt  = ST_SCAN;
                end
            end
            ST_SCAN: begin
                if (w_match) begin
                    w_count_nxt = r_count + COUNT_W'(1);
                    // First hit always recorded; later hits only when the highest is wanted.
                    if (!r_found || !PICK_LOWEST) begin
                        w_abcd_nxt = r_cand;
                    end
                    w_found_nxt = 1'b1;
                end
                if (r_cand == LAST_CAND) begin
                    w_state_nxt = ST_DONE;
                end else begin
                    w_cand_nxt = r_cand + CODE_W'(1);
                end
            end
            ST_DONE: begin
                // Valid rises one cycle after entering DONE, keeping the k+17 timing.
                w_rsp_valid_nxt = 1'b1;
                if (r_rsp_valid && i_bus.rsp_ready) begin
                    w_rsp_valid_nxt = 1'b0;
                    w_state_nxt     = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt     = ST_IDLE;
                w_rsp_valid_nxt = 1'b0;
            end
        endcase

        w_req_ready_nxt = (w_state_nxt == ST_IDLE);
        w_busy_nxt      = (w_state_nxt != ST_IDLE);
    end

    // State and registered outputs; synchronous reset discards any operation.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_target    <= '0;
            r_cand      <= '0;
            r_count     <= '0;
            r_abcd      <= '0;
            r_found     <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_req_ready <= 1'b1;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_target    <= w_target_nxt;
            r_cand      <= w_cand_nxt;
            r_count     <= w_count_nxt;
            r_abcd      <= w_abcd_nxt;
            r_found     <= w_found_nxt;
            r_rsp_valid <= w_rsp_valid_nxt;
            r_req_ready <= w_req_ready_nxt;
            r_busy      <= w_busy_nxt;
        end
    end

    assign i_bus.req_ready = r_req_ready;
    assign i_bus.rsp_valid = r_rsp_valid;
    assign i_bus.rsp_abcd  = r_abcd;
    assign i_bus.rsp_found = r_found;
    assign i_bus.rsp_count = r_count;
    assign i_bus.busy      = r_busy;

endmodule
